ram_ctrl: RTL and testbench
===========================

# ram_ctrl

Sequencing master for the 128 x 8 chip-select RAM. It sits directly upstream of the RAM. It accepts single-word read/write requests from a processor-side req/ack handshake and generates the RAM's cs1/cs2/rd/wr/addr strobes. It owns the shared bidirectional data bus `mag`: it drives the bus only during writes and captures it during reads.

## Interface
- `AW`, 7: address width; RAM depth is 2**AW words.
- `DW`, 8: data width.
- `RD_WAIT`, 0: extra wait cycles between asserting `ram_rd` and sampling `ram_mag`. Range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe, sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `a`  in  AW  word address; sampled with `req`.
- `wdata`  in  DW  write data; sampled with `req`.
- `rdata`  out  DW  read result; holds its value until the next read completes.
- `ack`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from request capture until the end of the ack cycle.
- `err`  out  1  verify mismatch; valid only while `ack`=1.
- `ram_cs1`, `ram_cs2`  out  1  RAM selects; the RAM is selected when cs1=1 and cs2=0.
- `ram_rd`, `ram_wr`  out  1  RAM read and write strobes.
- `ram_addr`  out  AW  RAM address.
- `ram_mag`  inout  DW  shared data bus; high-Z unless the block is driving it.

## Operation
- FSM states: IDLE, WR, RD, VRD, DONE.
- IDLE with `req`=1: latch `a`, `we` and `wdata`; set `busy`=1; go to WR if `we`=1, else RD.
- IDLE with `req`=0: stay in IDLE.
- WR:
  - Outputs: cs1=1, cs2=0, wr=1, rd=0, addr=latched address; drive `ram_mag` with the latched data.
  - The RAM captures the word at the next rising edge.
  - Next state: DONE, or VRD when verify is enabled.
- RD:
  - Outputs: cs1=1, cs2=0, rd=1, wr=0.
  - A down-counter loaded with `RD_WAIT` decrements once per cycle.
  - At the edge where the counter is 0: `rdata` <= `ram_mag`, then go to DONE.
- VRD: same sequence as RD, but the sample is compared with the latched write data. `err` <= (sample != data). `rdata` is not updated.
- DONE:
  - RAM strobes deasserted: cs1=0, cs2=1, rd=0, wr=0.
  - `ack`=1, then go to IDLE.
  - `busy` drops at the DONE-to-IDLE edge.
- Bus rule: `ram_mag` is driven only in WR. `ram_rd`=1 and block drive never overlap at any edge.
- `req` during a transaction (outside IDLE) is ignored.
- `req` held high across DONE starts a new transaction at the first IDLE edge. Back-to-back transactions therefore have one idle cycle between them.
- Address wraps naturally within AW bits; there is no range check.
- Reset asserted mid-operation aborts the transaction immediately: bus released, no `ack`, RAM contents undefined only at the in-flight address.

Reset values:
- `ram_cs1`=0, `ram_cs2`=1, `ram_rd`=0, `ram_wr`=0, `ram_addr`=0.
- `ram_mag`=Z.
- `rdata`=0, `ack`=0, `busy`=0, `err`=0.
- State IDLE.

## Timing
- All outputs, including the bus-enable, are registered. There are no combinational paths from inputs to outputs.
- Edge E0 is the edge that captures `req`.
- Write, verify disabled: WR during E0..E1; `ack` during E1..E2; latency 2 cycles.
- Read: RD during E0..E1+RD_WAIT; `ack` during the next cycle; latency 2+RD_WAIT cycles.
- Write, verify enabled: WR during E0..E1; VRD during E1..E2+RD_WAIT; then `ack`; latency 3+RD_WAIT cycles.
- WR to VRD turnaround: bus drive released on the same edge that raises `ram_rd`.

## Configuration
- Macro: `RAM_CTRL_VERIFY_EN`.
- Defined: every write is followed by the VRD read-back. `err` reports a mismatch in the ack cycle.
- Undefined: the VRD state, comparator and err register are compiled out. `err` is tied to 0 and writes complete after WR.

## Structure
- Shared package `ram_ctrl_pkg` holds:
  - the state enum (IDLE, WR, RD, VRD, DONE);
  - default `AW`/`DW` constants;
  - RAM-select idle constants: CS1_IDLE=0, CS2_IDLE=1.
- One sub-module, `ram_bus_drv`: tristate driver for `ram_mag` with an enable and a data input. It is also reused by the bench model.

## Test plan
- After reset, write 0xAA to address 10, then 0xFF to address 20. Required: each `ack` arrives 2 cycles after `req` (verify disabled), and `ram_mag` is Z outside WR.
- Read address 10, then address 20. Required: `rdata`=0xAA, then 0xFF, each with `ack` 2 cycles after `req`, and `rdata` held between reads.
- Run with `RD_WAIT`=3 and read address 20. Required: `ack` 5 cycles after `req`, and `ram_rd` high for 4 cycles.
- Hold `req`=1 continuously, alternating write 0x55 to address 127 and read of address 127. Required: reads return 0x55, exactly one idle cycle between transactions, and `req` is ignored while `busy`=1.
- Pull `rst_n` low in the middle of RD. Required: all outputs return to their reset values immediately, no `ack` is issued, and the next request after release completes normally.
- With `RAM_CTRL_VERIFY_EN` defined, write 0x3C to address 5 while the bench corrupts the read-back to 0x3D. Required: `err`=1 with `ack`; an uncorrupted write gives `err`=0.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl shared types and constants.
// Used by the RAM sequencing master and its processor-side interface.
package ram_ctrl_pkg;

   localparam int AW_DEF = 7;
   localparam int DW_DEF = 8;

   localparam logic CS1_IDLE = 1'b0;
   localparam logic CS2_IDLE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      VRD,
      DONE
   } state_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// Processor-side request/ack handshake of ram_ctrl.
// master = processor, slave = controller.
interface ram_ctrl_if #(
   parameter int AW = 7,
   parameter int DW = 8
);
   logic          req;
   logic          we;
   logic [AW-1:0] a;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;
   logic          ack;
   logic          busy;
   logic          err;

   modport master (
      output req, we, a, wdata,
      input  rdata, ack, busy, err
   );

   modport slave (
      input  req, we, a, wdata,
      output rdata, ack, busy, err
   );
endinterface

// File: rtl/ram_bus_drv.sv
// Tristate driver for the shared RAM data bus.
// Drives d onto bus while en is high, otherwise releases it.
module ram_bus_drv #(
   parameter int DW = 8
) (
   input  logic          en,
   input  logic [DW-1:0] d,
   inout  wire  [DW-1:0] bus
);
   assign bus = en ? d : {DW{1'bz}};
endmodule

// File: rtl/ram_ctrl.sv
// Sequencing master for the 128x8 chip-select RAM.
// Optional write read-back check: define RAM_CTRL_VERIFY_EN.
module ram_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int RD_WAIT = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   ram_ctrl_if.slave     host,
   output logic          ram_cs1,
   output logic          ram_cs2,
   output logic          ram_rd,
   output logic          ram_wr,
   output logic [AW-1:0] ram_addr,
   inout  wire  [DW-1:0] ram_mag
);

   state_t        st;
   logic [DW-1:0] wd_q;
   logic [DW-1:0] rdata_q;
   logic [3:0]    cnt;
   logic          drv_en;
   logic          ack_q;
   logic          busy_q;
   logic          err_q;

   assign host.rdata = rdata_q;
   assign host.ack   = ack_q;
   assign host.busy  = busy_q;
   assign host.err   = err_q;

   ram_bus_drv #(.DW(DW)) u_drv (
      .en  (drv_en),
      .d   (wd_q),
      .bus (ram_mag)
   );

`ifndef RAM_CTRL_VERIFY_EN
   assign err_q = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         ram_cs1  <= CS1_IDLE;
         ram_cs2  <= CS2_IDLE;
         ram_rd   <= 1'b0;
         ram_wr   <= 1'b0;
         ram_addr <= '0;
         wd_q     <= '0;
         rdata_q  <= '0;
         cnt      <= '0;
         drv_en   <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         unique case (st)
            IDLE: begin
               ack_q <= 1'b0;
               if (host.req) begin
                  ram_addr <= host.a;
                  wd_q     <= host.wdata;
                  busy_q   <= 1'b1;
                  ram_cs1  <= 1'b1;
                  ram_cs2  <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
                  err_q    <= 1'b0;
`endif
                  if (host.we) begin
                     st     <= WR;
                     ram_wr <= 1'b1;
                     drv_en <= 1'b1;
                  end else begin
                     st     <= RD;
                     ram_rd <= 1'b1;
                     cnt    <= 4'(RD_WAIT);
                  end
               end
            end
            WR: begin
               ram_wr <= 1'b0;
               drv_en <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
               // drive release and read strobe share this edge
               st     <= VRD;
               ram_rd <= 1'b1;
               cnt    <= 4'(RD_WAIT);
`else
               st      <= DONE;
               ram_cs1 <= CS1_IDLE;
               ram_cs2 <= CS2_IDLE;
               ack_q   <= 1'b1;
`endif
            end
            RD: begin
               if (cnt == 4'd0) begin
                  rdata_q <= ram_mag;
                  st      <= DONE;
                  ram_rd  <= 1'b0;
                  ram_cs1 <= CS1_IDLE;
                  ram_cs2 <= CS2_IDLE;
                  ack_q   <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
`ifdef RAM_CTRL_VERIFY_EN
            VRD: begin
               if (cnt == 4'd0) begin
                  err_q   <= (ram_mag != wd_q);
                  st      <= DONE;
                  ram_rd  <= 1'b0;
                  ram_cs1 <= CS1_IDLE;
                  ram_cs2 <= CS2_IDLE;
                  ack_q   <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
`endif
            DONE: begin
               ack_q  <= 1'b0;
               busy_q <= 1'b0;
               st     <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: table of single transactions plus
// back-to-back, long read, mid-read reset and verify sequences.
module tb_ram_ctrl;

   logic clk = 1'b0;
   logic rst0_n = 1'b0;
   logic rst3_n = 1'b0;
   always #5 clk = ~clk;

`ifdef RAM_CTRL_VERIFY_EN
   localparam int WLAT = 3;
`else
   localparam int WLAT = 2;
`endif

   ram_ctrl_if #(.AW(7), .DW(8)) if0 ();
   ram_ctrl_if #(.AW(7), .DW(8)) if3 ();

   logic       cs1_0, cs2_0, rd0, wr0;
   logic       cs1_3, cs2_3, rd3, wr3;
   logic [6:0] addr0, addr3;
   wire  [7:0] mag0, mag3;

   ram_ctrl #(.AW(7), .DW(8), .RD_WAIT(0)) dut0 (
      .clk(clk), .rst_n(rst0_n), .host(if0.slave),
      .ram_cs1(cs1_0), .ram_cs2(cs2_0), .ram_rd(rd0),
      .ram_wr(wr0), .ram_addr(addr0), .ram_mag(mag0)
   );

   ram_ctrl #(.AW(7), .DW(8), .RD_WAIT(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .host(if3.slave),
      .ram_cs1(cs1_3), .ram_cs2(cs2_3), .ram_rd(rd3),
      .ram_wr(wr3), .ram_addr(addr3), .ram_mag(mag3)
   );

   // RAM models behind each controller
   logic [7:0] mem0 [128];
   logic [7:0] mem3 [128];
   logic       corrupt = 1'b0;
   wire        sel0 = cs1_0 && !cs2_0;
   wire        sel3 = cs1_3 && !cs2_3;
   wire  [7:0] q0 = mem0[addr0] ^ {7'd0, corrupt};
   wire  [7:0] q3 = mem3[addr3];

   ram_bus_drv #(.DW(8)) u_m0 (.en(sel0 && rd0), .d(q0), .bus(mag0));
   ram_bus_drv #(.DW(8)) u_m3 (.en(sel3 && rd3), .d(q3), .bus(mag3));

   always @(posedge clk) begin
      if (sel0 && wr0) mem0[addr0] <= mag0;
      if (sel3 && wr3) mem3[addr3] <= mag3;
   end

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // bus rule: drive only with wr, never together with rd
   always @(negedge clk) begin
      chk("drv0_rule", {dut0.u_drv.en, dut0.u_drv.en && rd0},
          {wr0, 1'b0});
      chk("drv3_rule", {dut3.u_drv.en, dut3.u_drv.en && rd3},
          {wr3, 1'b0});
   end

   task automatic txn(input bit sel, input logic w,
                      input logic [6:0] ad, input logic [7:0] wd,
                      output int lat, output logic [7:0] rdv,
                      output logic ev, output int rdc);
      @(negedge clk);
      @(negedge clk);
      if (sel) begin
         if3.req = 1'b1; if3.we = w; if3.a = ad; if3.wdata = wd;
      end else begin
         if0.req = 1'b1; if0.we = w; if0.a = ad; if0.wdata = wd;
      end
      lat = 0; rdv = '0; ev = 1'b0; rdc = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) begin
            if0.req = 1'b0;
            if3.req = 1'b0;
         end
         if (sel ? rd3 : rd0) rdc++;
         if (sel ? if3.ack : if0.ack) begin
            lat = c;
            rdv = sel ? if3.rdata : if0.rdata;
            ev  = sel ? if3.err : if0.err;
            break;
         end
      end
      if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic       we;
      logic [6:0] a;
      logic [7:0] wd;
      logic [7:0] rd;
      int         lat;
   } vec_t;

   vec_t tbl [8];

   int         lat, rdc, gap, idl, nack, last;
   logic [7:0] rdv;
   logic       ev, wasb, curw;

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem0[i] = 8'h00;
         mem3[i] = 8'h00;
      end
      if0.req = 0; if0.we = 0; if0.a = 0; if0.wdata = 0;
      if3.req = 0; if3.we = 0; if3.a = 0; if3.wdata = 0;

      tbl[0] = '{1'b1, 7'd10,  8'hAA, 8'h00, WLAT};
      tbl[1] = '{1'b1, 7'd20,  8'hFF, 8'h00, WLAT};
      tbl[2] = '{1'b0, 7'd10,  8'h00, 8'hAA, 2};
      tbl[3] = '{1'b0, 7'd20,  8'h00, 8'hFF, 2};
      tbl[4] = '{1'b1, 7'd0,   8'h01, 8'hFF, WLAT};
      tbl[5] = '{1'b1, 7'd127, 8'h80, 8'hFF, WLAT};
      tbl[6] = '{1'b0, 7'd0,   8'h00, 8'h01, 2};
      tbl[7] = '{1'b0, 7'd127, 8'h00, 8'h80, 2};

      #12;
      chk("reset0",
          {cs1_0, cs2_0, rd0, wr0, addr0, if0.rdata,
           if0.ack, if0.busy, if0.err, dut0.u_drv.en},
          {1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 8'd0,
           1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      rst0_n = 1'b1;
      rst3_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         txn(1'b0, tbl[i].we, tbl[i].a, tbl[i].wd, lat, rdv, ev, rdc);
         chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d_rdata", i), rdv, tbl[i].rd);
         chk($sformatf("vec%0d_err", i), ev, 1'b0);
      end

      // back-to-back with req held high, alternating write/read
      @(negedge clk);
      @(negedge clk);
      if0.req = 1'b1; if0.we = 1'b1; if0.a = 7'd127; if0.wdata = 8'h55;
      nack = 0; idl = 0; last = 0; wasb = 1'b0; curw = 1'b1;
      for (int c = 0; c < 60 && nack < 4; c++) begin
         @(posedge clk);
         #1;
         if (!if0.busy) idl++;
         if (if0.busy && !wasb) begin
            curw = if0.we;
            if0.we = ~if0.we;
            if0.wdata = if0.we ? 8'h55 : 8'h00;
         end
         wasb = if0.busy;
         if (if0.ack) begin
            nack++;
            if (nack > 1) begin
               gap = c - last;
               chk("b2b_gap", gap, WLAT + 1 + (curw ? 0 : 2 - WLAT));
               chk("b2b_idle", idl, 1);
            end
            if (!curw) chk("b2b_rdata", if0.rdata, 8'h55);
            last = c;
            idl = 0;
         end
      end
      if0.req = 1'b0;
      chk("b2b_acks", nack, 4);

      // long read path and mid-read reset on the RD_WAIT=3 instance
      txn(1'b1, 1'b1, 7'd20, 8'hFF, lat, rdv, ev, rdc);
      chk("w3_lat", lat, WLAT + (WLAT - 2) * 3);
      @(negedge clk);
      @(negedge clk);
      if3.req = 1'b1; if3.we = 1'b0; if3.a = 7'd20;
      @(posedge clk);
      #1;
      if3.req = 1'b0;
      @(posedge clk);
      #2;
      rst3_n = 1'b0;
      #1;
      chk("rst_mid_rd",
          {cs1_3, cs2_3, rd3, wr3, addr3, if3.rdata,
           if3.ack, if3.busy, dut3.u_drv.en},
          {1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 8'd0,
           1'b0, 1'b0, 1'b0});
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         chk("rst_no_ack", if3.ack, 1'b0);
      end
      @(negedge clk);
      rst3_n = 1'b1;
      txn(1'b1, 1'b0, 7'd20, 8'h00, lat, rdv, ev, rdc);
      chk("rd3_lat", lat, 5);
      chk("rd3_rdata", rdv, 8'hFF);
      chk("rd3_rdcycles", rdc, 4);

`ifdef RAM_CTRL_VERIFY_EN
      corrupt = 1'b1;
      txn(1'b0, 1'b1, 7'd5, 8'h3C, lat, rdv, ev, rdc);
      corrupt = 1'b0;
      chk("vfy_bad_lat", lat, 3);
      chk("vfy_bad_err", ev, 1'b1);
      txn(1'b0, 1'b1, 7'd5, 8'h3C, lat, rdv, ev, rdc);
      chk("vfy_ok_err", ev, 1'b0);
      chk("vfy_ok_rdcycles", rdc, 1);
`endif

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
